// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the double-dabble BCD converter.
//   state_t        converter FSM states (IDLE, SHIFT, DONE)
//   BCD_ADJ_THRESH digit value at or above which the +3 correction applies
//   BCD_ADJ        correction added to a digit before each shift
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ        = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: combinational double-dabble correction for one BCD digit.
// A digit of 5 or more would become 10 or more after the next doubling, so
// adding 3 first makes the shift carry correctly into the next digit.
// Ports:
//   digit_in   in   4   scratch digit before the shift
//   digit_out  out  4   digit_in + 3 when digit_in >= 5, else digit_in
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in + BCD_ADJ) : digit_in;

endmodule

// File: rtl/bcd_converter.sv
// bcd_converter: iterative double-dabble binary-to-BCD converter, one shift per clock.
// A value is accepted in IDLE via in_valid/in_ready, shifted WIDTH times, then the
// packed BCD result is registered and held until the next conversion completes.
// Ports:
//   CLOCK_50   in   1         system clock, all state on posedge
//   reset_n    in   1         asynchronous active-low reset
//   in_valid   in   1         bin_in is valid this cycle
//   in_ready   out  1         converter idle, will accept bin_in
//   bin_in     in   WIDTH     unsigned binary value
//   out_valid  out  1         one-cycle pulse: bcd_out just updated
//   bcd_out    out  4*DIGITS  packed BCD, digit 0 (ones) in [3:0]
//   blank_out  out  DIGITS    leading-zero blank mask
// Configuration macro: BCD_LEADING_BLANK_EN enables the registered blank_out mask;
// without it blank_out is tied to zero.
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    // The largest input must fit in the digits provided; no saturation exists.
    generate
        if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : g_param_check
            $error("bcd_converter: DIGITS too small to hold 2**WIDTH-1");
        end
    endgenerate

    state_t                state;
    state_t                state_next;
    logic [WIDTH-1:0]      bin_reg;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   scratch_adj;
    logic [4*DIGITS-1:0]   scratch_shifted;
    logic [CNT_W-1:0]      count;
    logic                  last_shift;

    // Every digit gets its +3 correction in parallel before the shift.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_adjust
            bcd_digit_adjust u_adjust (
                .digit_in  (scratch[4*i +: 4]),
                .digit_out (scratch_adj[4*i +: 4])
            );
        end
    endgenerate

    // {scratch,bin} shifted left by one: the binary MSB enters the ones digit.
    assign scratch_shifted = {scratch_adj[4*DIGITS-2:0], bin_reg[WIDTH-1]};
    assign last_shift      = (count == LAST_SHIFT);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // bcd_out is only written on the final shift, so partial results never show.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bin_reg <= '0;
            scratch <= '0;
            count   <= '0;
            bcd_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_reg <= bin_in;
                        scratch <= '0;
                        count   <= '0;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_shifted;
                    bin_reg <= {bin_reg[WIDTH-2:0], 1'b0};
                    count   <= count + CNT_W'(1);
                    if (last_shift) begin
                        bcd_out <= scratch_shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic              higher_zero;
    logic [DIGITS-1:0] blank_reg;

    // Walk down from the top digit; the ones digit is never blanked so 0 shows "0".
    always_comb begin
        blank_next  = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero   = higher_zero && (scratch_shifted[4*i +: 4] == 4'd0);
            blank_next[i] = higher_zero;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            blank_reg <= '0;
        end else if (state == SHIFT && last_shift) begin
            blank_reg <= blank_next;
        end
    end

    assign blank_out = blank_reg;
`else
    assign blank_out = '0;
`endif

endmodule
